ibex_multdiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the Ibex EX stage. It supersedes the

---
 rtl/ibex_multdiv_iter_pkg.sv | 27 ++
 rtl/ibex_multdiv_iter_if.sv | 33 +++
 rtl/ibex_multdiv_iter_step.sv | 45 ++++
 rtl/ibex_multdiv_iter.sv | 148 ++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_multdiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM state encoding and unroll limits.
package ibex_multdiv_iter_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [2:0] {
    MDI_IDLE,
    MDI_ABS,
    MDI_COMP,
    MDI_FIXUP,
    MDI_DONE
  } md_iter_state_e;

  localparam int MDI_MAX_UNROLL = 8;

  // True for the two operations that run the restoring divider.
  function automatic logic is_div_op(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Request/result bundle of the iterative multiply/divide unit.
//
// Handshake: a request transfers on a rising clock edge where valid_i && ready_o;
// a result transfers on a rising edge where valid_o && ready_i. Once valid_o is
// high, it and result_o hold until the result transfers (or kill_i/rst_i).
// valid_i may rise without waiting for ready_o; ready_o never waits for valid_i.
import ibex_multdiv_iter_pkg::*;

interface ibex_multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  md_op_e           operator_i;
  logic [1:0]       signed_mode_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             kill_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  md_iter_state_e   state;      // debug view of the FSM state

  modport slave (
    input  valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, state
  );

  modport master (
    output valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, state
  );
endinterface

// File: rtl/ibex_multdiv_iter_step.sv
// One combinational radix-2 step. Multiply mode: LSB-first shift-add, where
// acc is the product, sh the shifted multiplicand and bits the remaining
// multiplier. Divide mode: MSB-first restoring subtract, where acc is the
// partial remainder, sh holds the divisor and bits shifts the dividend out
// while the quotient shifts in.
module ibex_multdiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] sh_i,
  input  logic [WIDTH-1:0]   bits_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] sh_o,
  output logic [WIDTH-1:0]   bits_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   divisor;
  logic [WIDTH+1:0] diff;

  // Single step of either algorithm; remainder stays below the divisor so it fits W bits.
  always_comb begin
    acc_o   = acc_i;
    sh_o    = sh_i;
    bits_o  = bits_i;
    rem_sh  = {acc_i[WIDTH-1:0], bits_i[WIDTH-1]};
    divisor = sh_i[WIDTH:0];
    diff    = {1'b0, rem_sh} - {1'b0, divisor};
    if (div_mode) begin
      bits_o = {bits_i[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH+1]) begin
        acc_o     = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
        bits_o[0] = 1'b1;
      end else begin
        acc_o = {{(WIDTH-1){1'b0}}, rem_sh};
      end
    end else begin
      if (bits_i[0]) acc_o = acc_i + sh_i;
      sh_o   = {sh_i[2*WIDTH-2:0], 1'b0};
      bits_o = {1'b0, bits_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit: IDLE -> ABS -> COMP -> FIXUP -> DONE, with
// UNROLL radix-2 steps per COMP cycle and early exit for MULL.
import ibex_multdiv_iter_pkg::*;

module ibex_multdiv_iter #(
  parameter int WIDTH      = 32,
  parameter int UNROLL     = 1,
  parameter int EARLY_TERM = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  ibex_multdiv_iter_if.slave md
);

  localparam int N     = WIDTH / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  md_iter_state_e     state_q, state_d;
  md_op_e             op_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic               sign_a_q, sign_b_q;
  logic [2*WIDTH-1:0] acc_q, sh_q;
  logic [WIDTH-1:0]   bits_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept, div_zero, div_mode, comp_last;
  logic [WIDTH:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

  logic [2*WIDTH-1:0] acc_c  [UNROLL+1];
  logic [2*WIDTH-1:0] sh_c   [UNROLL+1];
  logic [WIDTH-1:0]   bits_c [UNROLL+1];

  assign md.ready_o  = (state_q == MDI_IDLE) && !rst_i;
  assign md.valid_o  = (state_q == MDI_DONE);
  assign md.result_o = result_q;
  assign md.state    = state_q;

  assign accept   = md.valid_i && md.ready_o;
  assign div_zero = is_div_op(md.operator_i) && (md.op_b_i == '0);
  assign div_mode = is_div_op(op_q);

  // Magnitudes in a W+1-bit datapath so the most negative value stays exact.
  assign mag_a = sign_a_q ? -{1'b1, op_a_q} : {1'b0, op_a_q};
  assign mag_b = sign_b_q ? -{1'b1, op_b_q} : {1'b0, op_b_q};

  assign acc_c[0]  = acc_q;
  assign sh_c[0]   = sh_q;
  assign bits_c[0] = bits_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    ibex_multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (div_mode),
      .acc_i    (acc_c[g]),
      .sh_i     (sh_c[g]),
      .bits_i   (bits_c[g]),
      .acc_o    (acc_c[g+1]),
      .sh_o     (sh_c[g+1]),
      .bits_o   (bits_c[g+1])
    );
  end

  // COMP ends on the last counted cycle, or early once MULL has no multiplier bits left.
  assign comp_last = (cnt_q == '0) ||
                     ((EARLY_TERM != 0) && (op_q == MD_OP_MULL) && (bits_c[UNROLL] == '0));

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -bits_q : bits_q;
    rem_fix  = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    case (op_q)
      MD_OP_MULL: fix_result = prod_fix[WIDTH-1:0];
      MD_OP_MULH: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      MD_OP_DIV:  fix_result = quot_fix;
      default:    fix_result = rem_fix;
    endcase
  end

  // Next-state logic; kill_i forces IDLE from any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDI_IDLE:  if (accept) state_d = div_zero ? MDI_DONE : MDI_ABS;
      MDI_ABS:   state_d = MDI_COMP;
      MDI_COMP:  if (comp_last) state_d = MDI_FIXUP;
      MDI_FIXUP: state_d = MDI_DONE;
      MDI_DONE:  if (md.ready_i) state_d = MDI_IDLE;
      default:   state_d = MDI_IDLE;
    endcase
    if ((state_q != MDI_IDLE) && md.kill_i) state_d = MDI_IDLE;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= MDI_IDLE;
    else       state_q <= state_d;
  end

  // Operand capture, iteration datapath, counter and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= MD_OP_MULL;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      bits_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= md.operator_i;
        op_a_q   <= md.op_a_i;
        op_b_q   <= md.op_b_i;
        sign_a_q <= md.signed_mode_i[0] & md.op_a_i[WIDTH-1];
        sign_b_q <= md.signed_mode_i[1] & md.op_b_i[WIDTH-1];
        if (div_zero) result_q <= (md.operator_i == MD_OP_DIV) ? '1 : md.op_a_i;
      end
      case (state_q)
        MDI_ABS: begin
          acc_q <= '0;
          cnt_q <= CNT_W'(N - 1);
          if (div_mode) begin
            sh_q   <= {{(WIDTH-1){1'b0}}, mag_b};
            bits_q <= mag_a[WIDTH-1:0];
          end else begin
            sh_q   <= {{(WIDTH-1){1'b0}}, mag_a};
            bits_q <= mag_b[WIDTH-1:0];
          end
        end
        MDI_COMP: begin
          acc_q  <= acc_c[UNROLL];
          sh_q   <= sh_c[UNROLL];
          bits_q <= bits_c[UNROLL];
          cnt_q  <= cnt_q - 1'b1;
        end
        MDI_FIXUP: result_q <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Bench for ibex_multdiv_iter: three instances (UNROLL=1/ET=1, UNROLL=1/ET=0,
// UNROLL=4/ET=1) share stimulus; sel picks which one receives valid_i and is
// observed. Results and latencies are compared against an arithmetic model.
import ibex_multdiv_iter_pkg::*;

module tb_ibex_multdiv_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid, kill, ready;
  md_op_e      op;
  logic [1:0]  sm;
  logic [31:0] a, b;
  int          sel;

  int n_checks = 0;
  int n_pass   = 0;

  ibex_multdiv_iter_if #(.WIDTH(32)) if0 ();
  ibex_multdiv_iter_if #(.WIDTH(32)) if1 ();
  ibex_multdiv_iter_if #(.WIDTH(32)) if2 ();

  assign if0.valid_i = valid && (sel == 0);
  assign if1.valid_i = valid && (sel == 1);
  assign if2.valid_i = valid && (sel == 2);
  assign if0.operator_i = op;  assign if1.operator_i = op;  assign if2.operator_i = op;
  assign if0.signed_mode_i = sm; assign if1.signed_mode_i = sm; assign if2.signed_mode_i = sm;
  assign if0.op_a_i = a;  assign if1.op_a_i = a;  assign if2.op_a_i = a;
  assign if0.op_b_i = b;  assign if1.op_b_i = b;  assign if2.op_b_i = b;
  assign if0.kill_i = kill; assign if1.kill_i = kill; assign if2.kill_i = kill;
  assign if0.ready_i = ready; assign if1.ready_i = ready; assign if2.ready_i = ready;

  ibex_multdiv_iter #(.WIDTH(32), .UNROLL(1), .EARLY_TERM(1)) dut0 (.clk_i(clk), .rst_i(rst), .md(if0));
  ibex_multdiv_iter #(.WIDTH(32), .UNROLL(1), .EARLY_TERM(0)) dut1 (.clk_i(clk), .rst_i(rst), .md(if1));
  ibex_multdiv_iter #(.WIDTH(32), .UNROLL(4), .EARLY_TERM(1)) dut2 (.clk_i(clk), .rst_i(rst), .md(if2));

  logic           o_valid, o_ready;
  logic [31:0]    o_result;
  md_iter_state_e o_state;

  always_comb begin
    o_valid = if0.valid_o; o_ready = if0.ready_o; o_result = if0.result_o; o_state = if0.state;
    case (sel)
      1: begin o_valid = if1.valid_o; o_ready = if1.ready_o; o_result = if1.result_o; o_state = if1.state; end
      2: begin o_valid = if2.valid_o; o_ready = if2.ready_o; o_result = if2.result_o; o_state = if2.state; end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference result from plain integer arithmetic on the operand values.
  function automatic logic [31:0] ref_result(md_op_e o, logic [1:0] m, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = m[0] ? longint'($signed(x)) : longint'({32'b0, x});
    sy = m[1] ? longint'($signed(y)) : longint'({32'b0, y});
    p  = 64'(sx * sy);
    case (o)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV:  return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      default:    return (y == 0) ? x : 32'(sx % sy);
    endcase
  endfunction

  // Reference latency: cycles from accept until valid_o.
  function automatic int ref_latency(int s, md_op_e o, logic [1:0] m, logic [31:0] y);
    int u, c, len;
    logic [31:0] mag;
    u = (s == 2) ? 4 : 1;
    if ((o == MD_OP_DIV || o == MD_OP_REM) && y == 0) return 1;
    c = 32 / u;
    if (s != 1 && o == MD_OP_MULL) begin
      mag = (m[1] && y[31]) ? -y : y;
      len = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
      c = (len + u - 1) / u;
      if (c == 0) c = 1;
    end
    return c + 3;
  endfunction

  // Issue one request, measure latency, optionally hold backpressure, then consume.
  task automatic run_op(input int s, input md_op_e o, input logic [1:0] m,
                        input logic [31:0] x, input logic [31:0] y,
                        input int hold, input bit kill_acc);
    logic [31:0] exp_r;
    int exp_l, lat;
    exp_r = ref_result(o, m, x, y);
    exp_l = ref_latency(s, o, m, y);
    @(negedge clk);
    sel = s; op = o; sm = m; a = x; b = y; valid = 1'b1; kill = kill_acc;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; kill = 1'b0; a = $urandom; b = $urandom;
    op = md_op_e'($urandom_range(0, 3));
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val($sformatf("lat s%0d op%0d", s, o), 64'(lat), 64'(exp_l));
    check_val($sformatf("res s%0d op%0d %h,%h", s, o, x, y), 64'(o_result), 64'(exp_r));
    for (int i = 0; i < hold; i++) begin
      valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      check_val("bp_valid", 64'(o_valid), 64'd1);
      check_val("bp_result", 64'(o_result), 64'(exp_r));
      check_val("bp_ready", 64'(o_ready), 64'd0);
    end
    valid = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_val("idle_after", 64'(o_ready), 64'd1);
    check_val("valid_after", 64'(o_valid), 64'd0);
  endtask

  // Abort a DIV during COMP via kill_i or rst_i and confirm nothing is delivered.
  task automatic abort_test(input bit use_rst);
    int seen;
    @(negedge clk);
    sel = 0; op = MD_OP_DIV; sm = 2'b00; a = 32'd1000; b = 32'd7; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    @(negedge clk);
    check_val("abort_state", 64'(o_state), 64'(MDI_IDLE));
    check_val("abort_valid", 64'(o_valid), 64'd0);
    if (use_rst) begin
      check_val("rst_ready_low", 64'(o_ready), 64'd0);
      check_val("rst_result_zero", 64'(o_result), 64'd0);
    end else begin
      check_val("kill_ready", 64'(o_ready), 64'd1);
    end
    rst = 1'b0; kill = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check_val("abort_no_result", 64'(seen), 64'd0);
    run_op(0, MD_OP_MULL, 2'b00, 32'd3, 32'd3, 0, 1'b0);
  endtask

  initial begin : main
    md_op_e      ro;
    logic [31:0] rx, ry;
    int          wait_c;
    rst = 1'b1; valid = 1'b0; kill = 1'b0; ready = 1'b0;
    op = MD_OP_MULL; sm = 2'b00; a = '0; b = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_val($sformatf("rst_ready s%0d", s), 64'(o_ready), 64'd0);
      check_val($sformatf("rst_valid s%0d", s), 64'(o_valid), 64'd0);
      check_val($sformatf("rst_result s%0d", s), 64'(o_result), 64'd0);
      check_val($sformatf("rst_state s%0d", s), 64'(o_state), 64'(MDI_IDLE));
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;

    // Directed cases.
    run_op(0, MD_OP_MULL, 2'b00, 32'd7, 32'd6, 0, 1'b0);
    run_op(1, MD_OP_MULL, 2'b00, 32'd7, 32'd6, 0, 1'b0);
    run_op(0, MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(0, MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(0, MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    run_op(0, MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(0, MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(0, MD_OP_DIV,  2'b00, 32'h1234, 32'd0, 0, 1'b0);
    run_op(0, MD_OP_REM,  2'b00, 32'h1234, 32'd0, 0, 1'b0);
    run_op(0, MD_OP_REM,  2'b11, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    run_op(2, MD_OP_DIV,  2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op(2, MD_OP_REM,  2'b11, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);
    run_op(2, MD_OP_MULL, 2'b11, 32'd5, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(0, MD_OP_MULL, 2'b00, 32'd9, 32'd0, 0, 1'b0);

    // Backpressure with ignored requests, and kill_i in IDLE alongside an accept.
    run_op(0, MD_OP_DIV, 2'b11, 32'hFFFF_FC18, 32'd13, 10, 1'b0);
    run_op(2, MD_OP_MULH, 2'b11, 32'h1234_5678, 32'h8765_4321, 0, 1'b1);

    abort_test(1'b0);
    abort_test(1'b1);

    // kill_i in DONE drops the result.
    @(negedge clk);
    sel = 0; op = MD_OP_MULL; sm = 2'b00; a = 32'd5; b = 32'd5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_c = 0;
    while (!o_valid && wait_c < 60) begin
      @(negedge clk);
      wait_c++;
    end
    check_val("kd_reached", 64'(o_valid), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_val("kd_valid", 64'(o_valid), 64'd0);
    check_val("kd_ready", 64'(o_ready), 64'd1);

    // Randomized traffic with corner-biased operands.
    for (int n = 0; n < 150; n++) begin
      ro = md_op_e'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = $urandom_range(0, 15);
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = '0;
        default: ;
      endcase
      run_op($urandom_range(0, 2), ro, 2'($urandom_range(0, 3)), rx, ry,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
